// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences the shared
// PC/memory/ALU/register-file datapath and stalls on the memory-ready handshake.
module multicycle_ctrl_fsm #(
  parameter bit          STALL_EN = 1'b1,
  parameter int unsigned STATE_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ResultSrc,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         ImmSrc,
  output logic               IllegalOp,
  output logic               Retire,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_ALUWB   = 4'd7,
    S_EXECI   = 4'd8,
    S_JAL     = 4'd9,
    S_BEQ     = 4'd10,
    S_JALRADR = 4'd11
  } state_t;

  state_t state, next_state;
  logic   ready;
  logic   ir_write_raw, pc_update, branch, mem_write_raw, reg_write_raw;

  assign ready = STALL_EN ? MemReady : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next state and Moore outputs; architectural write enables are gated by reset below.
  always_comb begin
    next_state    = state;
    AdrSrc        = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    ResultSrc     = 2'b00;
    IllegalOp     = 1'b0;
    Retire        = 1'b0;
    ir_write_raw  = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = ready;
        pc_update    = ready;
        if (ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          OP_JALR:      next_state = S_JALRADR;
          default: begin
            IllegalOp  = 1'b1;
            Retire     = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWR;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        Retire        = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        Retire        = ready;
        if (ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        Retire        = 1'b1;
        next_state    = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        branch     = 1'b1;
        Retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_JALRADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = S_JAL;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms the link value OldPC+4.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
  end

  assign IRWrite  = ir_write_raw & ~reset;
  assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
  assign MemWrite = mem_write_raw & ~reset;
  assign RegWrite = reg_write_raw & ~reset;

  // Immediate format select, decoded straight from the opcode.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: each scenario queues per-cycle
// stimulus with expected outputs, then replays and compares them.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic       MemReady;
  logic       AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, IllegalOp, Retire;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;
  logic [3:0] state_o;
  logic [20:0] obs;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        zero;
    logic [6:0]  opc;
    logic [20:0] exp;
  } entry_t;

  entry_t sb[$];
  entry_t e;
  int checks   = 0;
  int failures = 0;

  multicycle_ctrl_fsm #(.STALL_EN(1'b1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .MemReady(MemReady),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .IllegalOp(IllegalOp), .Retire(Retire),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign obs = {state_o, AdrSrc, IRWrite, PCWrite, ALUSrcA, ALUSrcB, ALUOp,
                ResultSrc, MemWrite, RegWrite, ImmSrc, IllegalOp, Retire};

  // Packs one expected output set in the same order as obs.
  function automatic logic [20:0] mk(input int st, adr, irw, pcw, srca, srcb, aluop,
                                     rsrc, mw, rw, imm, ill, ret);
    return {4'(st), 1'(adr), 1'(irw), 1'(pcw), 2'(srca), 2'(srcb), 2'(aluop),
            2'(rsrc), 1'(mw), 1'(rw), 2'(imm), 1'(ill), 1'(ret)};
  endfunction

  task automatic push(input logic rst, rdy, zero, input logic [6:0] opc,
                      input logic [20:0] exp);
    entry_t n;
    n.rst = rst; n.rdy = rdy; n.zero = zero; n.opc = opc; n.exp = exp;
    sb.push_back(n);
  endtask

  task automatic test_reset();
    reset = 1'b1; MemReady = 1'b1; Zero = 1'b0; op = OP_R;
    @(negedge clk);
    push(1, 1, 0, OP_R, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(1, 1, 0, OP_R, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_R, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_R, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    push(1, 1, 0, OP_R, mk(6, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0));
    push(1, 1, 0, OP_R, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_R, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_R, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_R, mk(6, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0));
    push(1, 1, 0, OP_R, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    push(0, 1, 0, OP_SW, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 1, 0, 0));
    push(0, 1, 0, OP_SW, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    push(0, 1, 0, OP_SW, mk(2, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0));
    push(1, 0, 0, OP_SW, mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int n = 0; sb.size() > 0; n++) begin
      e = sb.pop_front();
      reset = e.rst; MemReady = e.rdy; Zero = e.zero; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL reset step %0d: got %h expected %h", n, obs, e.exp);
      end
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    push(0, 1, 0, OP_LW, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_LW, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_LW, mk(2, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_LW, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_LW, mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    for (int n = 0; sb.size() > 0; n++) begin
      e = sb.pop_front();
      reset = e.rst; MemReady = e.rdy; Zero = e.zero; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL lw step %0d: got %h expected %h", n, obs, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_stall();
    push(0, 1, 0, OP_SW, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 1, 0, 0));
    push(0, 1, 0, OP_SW, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    push(0, 0, 0, OP_SW, mk(2, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++)
      push(0, 0, 0, OP_SW, mk(5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    push(0, 1, 0, OP_SW, mk(5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    for (int n = 0; sb.size() > 0; n++) begin
      e = sb.pop_front();
      reset = e.rst; MemReady = e.rdy; Zero = e.zero; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL sw_stall step %0d: got %h expected %h", n, obs, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      push(0, 1, 1'(z), OP_BEQ, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 2, 0, 0));
      push(0, 1, 1'(z), OP_BEQ, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 0, 0));
      push(0, 1, 1'(z), OP_BEQ, mk(10, 0, 0, z, 2, 0, 1, 0, 0, 0, 2, 0, 1));
    end
    for (int n = 0; sb.size() > 0; n++) begin
      e = sb.pop_front();
      reset = e.rst; MemReady = e.rdy; Zero = e.zero; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL beq step %0d: got %h expected %h", n, obs, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jumps();
    push(0, 1, 0, OP_JALR, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_JALR, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_JALR, mk(11, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_JALR, mk(9, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_JALR, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    push(0, 1, 0, OP_JAL, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 3, 0, 0));
    push(0, 1, 0, OP_JAL, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3, 0, 0));
    push(0, 1, 0, OP_JAL, mk(9, 0, 0, 1, 1, 2, 0, 0, 0, 0, 3, 0, 0));
    push(0, 1, 0, OP_JAL, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1));
    for (int n = 0; sb.size() > 0; n++) begin
      e = sb.pop_front();
      reset = e.rst; MemReady = e.rdy; Zero = e.zero; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL jumps step %0d: got %h expected %h", n, obs, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    push(0, 0, 1, OP_BAD, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 0, 1, OP_BAD, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_BAD, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_BAD, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    push(0, 0, 0, OP_BAD, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_BAD, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 0, OP_BAD, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    for (int n = 0; sb.size() > 0; n++) begin
      e = sb.pop_front();
      reset = e.rst; MemReady = e.rdy; Zero = e.zero; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL illegal step %0d: got %h expected %h", n, obs, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    push(0, 1, 1, OP_I, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_I, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_I, mk(8, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_I, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    push(0, 1, 1, OP_R, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_R, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_R, mk(6, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_R, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    push(0, 1, 1, OP_LW, mk(0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_LW, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_LW, mk(2, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 0, 1, OP_LW, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_LW, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 1, OP_LW, mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    for (int n = 0; sb.size() > 0; n++) begin
      e = sb.pop_front();
      reset = e.rst; MemReady = e.rdy; Zero = e.zero; op = e.opc;
      #1;
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL back_to_back step %0d: got %h expected %h", n, obs, e.exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; op = OP_R; Zero = 1'b0; MemReady = 1'b1;
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq();
    test_jumps();
    test_illegal();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control FSM for the multicycle RV32I core. It replaces the single-cycle main decoder.
- Sequences the shared PC/memory/ALU/register-file datapath over 3–5 states per instruction.
- Supports lw, sw, R-type, I-type ALU, beq, jal and jalr.
- Stalls on a memory-ready handshake. The ALU decoder consumes ALUOp; the datapath consumes all other outputs.

Parameters:
STALL_EN, 1, 1 = honour MemReady; 0 = treat MemReady as always 1
STATE_W, 4, state register width (debug output width)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op  in  7  Instr[6:0] from instruction register
Zero  in  1  ALU zero flag
MemReady  in  1  memory access completes this cycle
AdrSrc  out  1  0=PC, 1=Result
IRWrite  out  1  latch instruction/OldPC
PCWrite  out  1  PC write enable
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 reg A
ALUSrcB  out  2  00=rs2 WriteData, 01=ImmExt, 10=const 4
ALUOp  out  2  00 add, 01 sub/branch, 10 funct-decoded
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
MemWrite  out  1  data memory write
RegWrite  out  1  register file write
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J (combinational from op)
IllegalOp  out  1  one-cycle pulse: unsupported opcode in Decode
Retire  out  1  high in the final state of each instruction
state_o  out  STATE_W  current state (debug)

Behaviour:
- Moore FSM; outputs not listed for a state are 0. Encoding: Fetch=0, Decode=1, MemAdr=2, MemRead=3, MemWB=4, MemWr=5, ExecR=6, ALUWB=7, ExecI=8, JAL=9, BEQ=10, JalrAdr=11.
- Reset: state <= Fetch at the next edge. While reset=1, IRWrite, PCWrite, RegWrite and MemWrite are forced 0.
- Reset mid-instruction aborts the instruction; no partial writes occur in the reset cycle.
- Fetch: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite=1 and PCUpdate=1 only when MemReady=1.
  - Otherwise hold Fetch with no enables. Go to Decode on MemReady.
- Decode: ALUSrcA=01, ALUSrcB=01 (computes branch/jal target into ALUOut). Next state by op:
  - 0000011/0100011 -> MemAdr
  - 0110011 -> ExecR
  - 0010011 -> ExecI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 1100111 -> JalrAdr
  - otherwise IllegalOp=1, Retire=1 -> Fetch
- MemAdr: ALUSrcA=10, ALUSrcB=01. lw -> MemRead; sw -> MemWr.
- MemRead: AdrSrc=1, ResultSrc=00. Hold until MemReady, then -> MemWB.
- MemWB: ResultSrc=01, RegWrite=1, Retire=1 -> Fetch.
- MemWr: AdrSrc=1, ResultSrc=00, MemWrite=1 held while waiting. On MemReady: Retire=1 -> Fetch.
- ExecR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ExecI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1 -> Fetch.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, Retire=1 -> Fetch.
- JalrAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (ALUOut <= rs1+imm) -> JAL.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1 (PC <= ALUOut target; ALU computes OldPC+4) -> ALUWB.
  - Target bit 0 clearing for jalr is done in the datapath.
- PCWrite = PCUpdate | (Branch & Zero). This is the only output depending on an input other than op/MemReady.
- Cycle counts with MemReady=1 throughout: lw 5, sw 4, R/I 4, beq 3, jal 4, jalr 5.
- ImmSrc decode: lw/I-type/jalr=00, sw=01, beq=10, jal=11, others 00.
- With STALL_EN=0, MemReady is ignored.

Test Plan:
- Reset held 2 cycles mid-ExecR -> state_o=0 after the first edge; no RegWrite/PCWrite during reset; Fetch resumes on deassert.
- lw (op=0000011), MemReady=1 -> states 0,1,2,3,4; RegWrite=1 and ResultSrc=01 only in state 4; Retire once.
- sw with MemReady low 3 cycles in MemWr -> MemWrite=1 for 4 consecutive cycles, AdrSrc=1; -> Fetch on ready.
- beq, Zero=1 -> PCWrite=1 in BEQ. Zero=0 -> PCWrite=0. Both take 3 cycles.
- jalr (1100111) -> states 0,1,11,9,7; PCWrite in 9; RegWrite with ResultSrc=00 in 7. jal skips 11.
- op=1111111 -> IllegalOp pulse in Decode, Retire=1, next state Fetch; Fetch stall with MemReady=0 keeps IRWrite=0 and PCWrite=0.
